// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the BRAM stream reader: FSM encodings, skid FIFO depth
// and the read-credit helper used to keep the FIFO from overflowing.
package bram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH     = 2;
  localparam int FIFO_CNT_WIDTH = $clog2(FIFO_DEPTH + 1);

  // A new read is safe when the words already owed to the FIFO (in flight plus
  // stored, minus the one leaving this cycle) leave room for it next cycle.
  function automatic logic has_credit(input logic inflight,
                                      input logic [FIFO_CNT_WIDTH-1:0] count,
                                      input logic pop);
    logic [2:0] occupancy;
    occupancy = 3'(inflight) + 3'(count) - 3'(pop);
    return occupancy < 3'(FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO holding {tlast, tdata} between the BRAM read port and the
// AXI-Stream output; push/pop in the same cycle leaves the count unchanged.
module stream_skid_fifo
  import bram_stream_reader_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          head,
  output logic                      empty,
  output logic [FIFO_CNT_WIDTH-1:0] count
);

  logic [WIDTH-1:0]          entry_reg [FIFO_DEPTH];
  logic                      wr_ptr_reg;
  logic                      rd_ptr_reg;
  logic [FIFO_CNT_WIDTH-1:0] count_reg;
  logic                      do_pop;

  assign do_pop = pop && (count_reg != '0);
  assign head   = entry_reg[rd_ptr_reg];
  assign empty  = (count_reg == '0);
  assign count  = count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        entry_reg[i] <= '0;
      end
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        entry_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg            <= ~wr_ptr_reg;
      end
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, do_pop})
        2'b10:   count_reg <= count_reg + FIFO_CNT_WIDTH'(1);
        2'b01:   count_reg <= count_reg - FIFO_CNT_WIDTH'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Sweeps LEN narrow BRAM words from BASE and streams them out over AXI-Stream.
// Optional stall counter output enabled by defining BRAM_READER_STALL_CNT_EN.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  enb,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] doutb,
  input  logic                  validb,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
`ifdef BRAM_READER_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  state_t                    state_reg, state_next;
  logic [ADDR_WIDTH-1:0]     addr_reg, addr_next;
  logic [LEN_WIDTH-1:0]      remaining_reg, remaining_next;
  logic                      done_reg, done_next;
  logic                      inflight_reg;
  logic                      last_inflight_reg;

  logic [DATA_WIDTH:0]       fifo_head;
  logic                      fifo_empty;
  logic [FIFO_CNT_WIDTH-1:0] fifo_count;
  logic                      pop;
  logic                      push;
  logic                      credit_ok;
  logic                      accept;
  logic                      last_issue;

  assign accept     = (state_reg == ST_IDLE) && start;
  assign pop        = m_axis_tvalid && m_axis_tready;
  // Stray read data arriving right after a reset abort has no matching issue.
  assign push       = validb && inflight_reg;
  assign credit_ok  = has_credit(inflight_reg, fifo_count, pop);
  assign last_issue = enb && (remaining_reg == LEN_WIDTH'(1));

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    done_next      = 1'b0;
    enb            = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_next     = ST_ISSUE;
            addr_next      = base_addr;
            remaining_next = len;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (credit_ok) begin
          enb            = 1'b1;
          addr_next      = addr_reg + ADDR_WIDTH'(1);
          remaining_next = remaining_reg - LEN_WIDTH'(1);
          if (remaining_reg == LEN_WIDTH'(1)) begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && m_axis_tlast) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= ST_IDLE;
      addr_reg          <= '0;
      remaining_reg     <= '0;
      done_reg          <= 1'b0;
      inflight_reg      <= 1'b0;
      last_inflight_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      addr_reg          <= addr_next;
      remaining_reg     <= remaining_next;
      done_reg          <= done_next;
      inflight_reg      <= enb;
      last_inflight_reg <= last_issue;
    end
  end

  // tlast rides alongside its data word so backpressure cannot separate them.
  stream_skid_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({last_inflight_reg, doutb}),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign busy          = (state_reg != ST_IDLE);
  assign done          = done_reg;
  assign addrb         = addr_reg;
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_head[DATA_WIDTH-1:0];
  assign m_axis_tlast  = !fifo_empty && fifo_head[DATA_WIDTH];

`ifdef BRAM_READER_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      stall_cnt_reg <= '0;
    end else if (m_axis_tvalid && !m_axis_tready && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a 1-cycle-latency BRAM model.
// Stall-counter scenario runs only when BRAM_READER_STALL_CNT_EN is defined.
module tb_bram_stream_reader;

  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int LW    = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, enb;
  logic [AW-1:0] addrb;
  logic [DW-1:0] doutb = '0;
  logic          validb = 1'b0;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast;
  logic          tready = 1'b0;
`ifdef BRAM_READER_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] got_data [$];
  logic          got_last [$];
  logic [AW-1:0] got_addr [$];
  int            outstanding = 0;
  int            max_out = 0;
  int            done_total = 0;

  always #5 clk = ~clk;

  bram_stream_reader #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .len           (len),
    .busy          (busy),
    .done          (done),
    .enb           (enb),
    .addrb         (addrb),
    .doutb         (doutb),
    .validb        (validb),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast)
`ifdef BRAM_READER_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  // BRAM port B: registered read, valid one cycle after enable.
  always @(posedge clk) begin
    validb <= enb;
    if (enb) doutb <= mem[addrb];
  end

  // Monitor at negedge: values are stable and describe the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
    end else begin
      if (enb) begin
        got_addr.push_back(addrb);
        outstanding++;
      end
      if (tvalid && tready) begin
        got_data.push_back(tdata);
        got_last.push_back(tlast);
        outstanding--;
      end
      if (done) done_total++;
      if (outstanding > max_out) max_out = outstanding;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input logic [AW-1:0] b, input logic [LW-1:0] l);
    start = 1'b1;
    base_addr = b;
    len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (enb !== 1'b0) begin failures++; $display("FAIL reset_enb got=%b exp=0", enb); end
    checks++; if (addrb !== 8'h00) begin failures++; $display("FAIL reset_addrb got=%h exp=00", addrb); end
    checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", tvalid); end
    checks++; if (tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b exp=0", tlast); end
    rst = 1'b0;
    tick();
    $display("reset released busy=%b tvalid=%b", busy, tvalid);
  endtask

  task automatic test_basic();
    logic [AW-1:0] a;
    tready = 1'b1;
    issue_start(8'h10, 9'd4);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
    checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL basic_lat1 tvalid got=%b exp=0", tvalid); end
    tick();
    checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL basic_lat2 tvalid got=%b exp=0", tvalid); end
    tick();
    for (int i = 0; i < 4; i++) begin
      a = 8'h10 + 8'(i);
      checks++; if (tvalid !== 1'b1) begin failures++; $display("FAIL basic_tvalid beat=%0d got=%b exp=1", i, tvalid); end
      checks++; if (tdata !== mem[a]) begin failures++; $display("FAIL basic_tdata beat=%0d got=%h exp=%h", i, tdata, mem[a]); end
      checks++; if (tlast !== (i == 3)) begin failures++; $display("FAIL basic_tlast beat=%0d got=%b exp=%b", i, tlast, (i == 3)); end
      tick();
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
    checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL basic_tvalid_end got=%b exp=0", tvalid); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    $display("cmd base=10 len=4 delivered");
  endtask

  task automatic test_wrap();
    int s, sa, dt;
    bit to;
    logic [AW-1:0] a;
    tready = 1'b1;
    s = got_data.size();
    sa = got_addr.size();
    dt = done_total;
    issue_start(8'hFE, 9'd4);
    tick();
    // A second command while busy must be ignored.
    issue_start(8'h00, 9'd3);
    wait_done(40, to);
    checks++; if (to) begin failures++; $display("FAIL wrap_timeout got=timeout exp=done"); end
    repeat (6) tick();
    checks++; if (got_data.size() - s !== 4) begin failures++; $display("FAIL wrap_beats got=%0d exp=4", got_data.size() - s); end
    checks++; if (got_addr.size() - sa !== 4) begin failures++; $display("FAIL wrap_issues got=%0d exp=4", got_addr.size() - sa); end
    checks++; if (done_total - dt !== 1) begin failures++; $display("FAIL wrap_done_count got=%0d exp=1", done_total - dt); end
    for (int i = 0; i < 4; i++) begin
      a = 8'hFE + 8'(i);
      if (sa + i < got_addr.size()) begin
        checks++; if (got_addr[sa+i] !== a) begin failures++; $display("FAIL wrap_addr idx=%0d got=%h exp=%h", i, got_addr[sa+i], a); end
      end
      if (s + i < got_data.size()) begin
        checks++; if (got_data[s+i] !== mem[a]) begin failures++; $display("FAIL wrap_data idx=%0d got=%h exp=%h", i, got_data[s+i], mem[a]); end
        checks++; if (got_last[s+i] !== (i == 3)) begin failures++; $display("FAIL wrap_last idx=%0d got=%b exp=%b", i, got_last[s+i], (i == 3)); end
      end
    end
    $display("cmd base=fe len=4 beats=%0d", got_data.size() - s);
  endtask

  task automatic test_backpressure();
    int s, c;
    bit seen_done;
    logic [AW-1:0] a;
    s = got_data.size();
    seen_done = 1'b0;
    tready = 1'b0;
    issue_start(8'h40, 9'd8);
    for (c = 0; c < 300; c++) begin
      tready = 1'($urandom_range(0, 1));
      tick();
      if (done) begin
        seen_done = 1'b1;
        break;
      end
    end
    tready = 1'b1;
    repeat (4) tick();
    checks++; if (!seen_done) begin failures++; $display("FAIL bp_timeout got=timeout exp=done"); end
    checks++; if (got_data.size() - s !== 8) begin failures++; $display("FAIL bp_beats got=%0d exp=8", got_data.size() - s); end
    checks++; if (max_out > 2) begin failures++; $display("FAIL bp_credit outstanding got=%0d exp<=2", max_out); end
    for (int i = 0; i < 8; i++) begin
      a = 8'h40 + 8'(i);
      if (s + i < got_data.size()) begin
        checks++; if (got_data[s+i] !== mem[a]) begin failures++; $display("FAIL bp_data idx=%0d got=%h exp=%h", i, got_data[s+i], mem[a]); end
        checks++; if (got_last[s+i] !== (i == 7)) begin failures++; $display("FAIL bp_last idx=%0d got=%b exp=%b", i, got_last[s+i], (i == 7)); end
      end
    end
    $display("cmd base=40 len=8 random tready beats=%0d cycles=%0d", got_data.size() - s, c);
  endtask

  task automatic test_zero_len();
    int s, sa;
    tready = 1'b1;
    s = got_data.size();
    sa = got_addr.size();
    issue_start(8'h55, 9'd0);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b exp=0", busy); end
    checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL zero_tvalid got=%b exp=0", tvalid); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_done_pulse got=%b exp=0", done); end
    repeat (4) tick();
    checks++; if (got_data.size() !== s) begin failures++; $display("FAIL zero_beats got=%0d exp=0", got_data.size() - s); end
    checks++; if (got_addr.size() !== sa) begin failures++; $display("FAIL zero_issues got=%0d exp=0", got_addr.size() - sa); end
    $display("cmd base=55 len=0 done pulse only");
  endtask

  task automatic test_reset_mid();
    int s, dt;
    bit to, reached;
    tready = 1'b1;
    s = got_data.size();
    reached = 1'b0;
    issue_start(8'h80, 9'd8);
    for (int c = 0; c < 30; c++) begin
      tick();
      if (got_data.size() - s >= 3) begin
        reached = 1'b1;
        break;
      end
    end
    checks++; if (!reached) begin failures++; $display("FAIL rstmid_three_beats got=%0d exp=3", got_data.size() - s); end
    dt = done_total;
    rst = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done); end
    checks++; if (enb !== 1'b0) begin failures++; $display("FAIL rstmid_enb got=%b exp=0", enb); end
    checks++; if (addrb !== 8'h00) begin failures++; $display("FAIL rstmid_addrb got=%h exp=00", addrb); end
    checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL rstmid_tvalid got=%b exp=0", tvalid); end
    checks++; if (tlast !== 1'b0) begin failures++; $display("FAIL rstmid_tlast got=%b exp=0", tlast); end
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL rstmid_stale_tvalid got=%b exp=0", tvalid); end
    checks++; if (done_total !== dt) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", done_total - dt); end
    s = got_data.size();
    issue_start(8'h20, 9'd2);
    wait_done(30, to);
    checks++; if (to) begin failures++; $display("FAIL rstmid_new_timeout got=timeout exp=done"); end
    tick();
    checks++; if (got_data.size() - s !== 2) begin failures++; $display("FAIL rstmid_new_beats got=%0d exp=2", got_data.size() - s); end
    if (got_data.size() - s >= 2) begin
      checks++; if (got_data[s] !== mem[8'h20]) begin failures++; $display("FAIL rstmid_new_d0 got=%h exp=%h", got_data[s], mem[8'h20]); end
      checks++; if (got_data[s+1] !== mem[8'h21]) begin failures++; $display("FAIL rstmid_new_d1 got=%h exp=%h", got_data[s+1], mem[8'h21]); end
      checks++; if (got_last[s+1] !== 1'b1 || got_last[s] !== 1'b0) begin failures++; $display("FAIL rstmid_new_last got=%b%b exp=01", got_last[s], got_last[s+1]); end
    end
    $display("cmd base=80 len=8 aborted; cmd base=20 len=2 beats=%0d", got_data.size() - s);
  endtask

`ifdef BRAM_READER_STALL_CNT_EN
  task automatic test_stall_cnt();
    bit to;
    tready = 1'b0;
    issue_start(8'h30, 9'd2);
    checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL stall_clear got=%0d exp=0", stall_cnt); end
    tick();
    tick();
    checks++; if (tvalid !== 1'b1) begin failures++; $display("FAIL stall_first_tvalid got=%b exp=1", tvalid); end
    repeat (5) tick();
    tready = 1'b1;
    checks++; if (stall_cnt !== 32'd5) begin failures++; $display("FAIL stall_cnt got=%0d exp=5", stall_cnt); end
    wait_done(20, to);
    checks++; if (to) begin failures++; $display("FAIL stall_timeout got=timeout exp=done"); end
    checks++; if (stall_cnt !== 32'd5) begin failures++; $display("FAIL stall_cnt_end got=%0d exp=5", stall_cnt); end
    $display("cmd base=30 len=2 stall_cnt=%0d", stall_cnt);
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 8'(i * 3 + 8'h11);
    end
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
`ifdef BRAM_READER_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
